// File: rtl/fft_input_loader.sv
// Loads one frame of ADC samples into FFT memory at bit-reversed addresses,
// then hands the frame to the FFT core. Optional overrun counter: FFT_INPUT_LOADER_OVERRUN_CNT_EN.
module fft_input_loader #(
    parameter int SAMPLE_W = 12,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    output logic                gen_inc,
    output logic                gen_clr,
    input  logic [ADDR_W-1:0]   gen_addr,
    input  logic                gen_full,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                fft_start,
    input  logic                fft_done,
    output logic                busy,
`ifdef FFT_INPUT_LOADER_OVERRUN_CNT_EN
    output logic [15:0]         overrun_cnt,
`endif
    output logic [15:0]         frame_cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        FLUSH    = 3'd2,
        START    = 3'd3,
        WAIT_FFT = 3'd4
    } state_t;

    state_t state_r;
    state_t next_state_s;

    logic                accept_s;
    logic                gen_inc_s;
    logic                gen_clr_s;
    logic                frame_inc_s;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic                fft_start_r;
    logic [15:0]         frame_cnt_r;

    // Offset binary to two's complement (invert MSB), left-justified in the memory word.
    function automatic logic [DATA_W-1:0] to_twos(input logic [SAMPLE_W-1:0] s);
        logic [DATA_W-1:0] w;
        w = {DATA_W{1'b0}};
        w[DATA_W-1 -: SAMPLE_W] = s ^ {1'b1, {(SAMPLE_W-1){1'b0}}};
        return w;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        gen_inc_s    = 1'b0;
        gen_clr_s    = 1'b0;
        frame_inc_s  = 1'b0;
        case (state_r)
            IDLE: begin
                gen_clr_s = 1'b1;
                if (run) begin
                    next_state_s = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                if (sample_valid) begin
                    accept_s = 1'b1;
                    // The final sample must not advance the generator past the frame end.
                    if (gen_full) begin
                        next_state_s = FLUSH;
                    end else begin
                        gen_inc_s    = 1'b1;
                        next_state_s = LOAD;
                    end
                end else begin
                    next_state_s = LOAD;
                end
            end
            FLUSH: begin
                next_state_s = START;
            end
            START: begin
                gen_clr_s    = 1'b1;
                next_state_s = WAIT_FFT;
            end
            WAIT_FFT: begin
                if (fft_done) begin
                    frame_inc_s = 1'b1;
                    if (run) begin
                        next_state_s = LOAD;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = WAIT_FFT;
                end
            end
            default: begin
                gen_clr_s    = 1'b1;
                next_state_s = IDLE;
            end
        endcase
    end

    // Generator handshake; reset forces the idle pattern even mid-frame.
    always_comb begin
        gen_inc = 1'b0;
        gen_clr = 1'b1;
        if (rst) begin
            gen_inc = 1'b0;
            gen_clr = 1'b1;
        end else begin
            gen_inc = gen_inc_s;
            gen_clr = gen_clr_s;
        end
    end

    // Memory write port, one cycle behind acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            mem_we_r <= accept_s;
            if (accept_s) begin
                mem_addr_r  <= gen_addr;
                mem_wdata_r <= to_twos(sample_data);
            end else begin
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    // FFT start pulse coincides with the START state.
    always_ff @(posedge clk) begin
        if (rst) begin
            fft_start_r <= 1'b0;
        end else begin
            fft_start_r <= (next_state_s == START);
        end
    end

    // Completed-frame counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= 16'd0;
        end else if (frame_inc_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

`ifdef FFT_INPUT_LOADER_OVERRUN_CNT_EN
    logic [15:0] overrun_cnt_r;
    logic        overrun_hit_s;

    assign overrun_hit_s = sample_valid &&
                           ((state_r == FLUSH) || (state_r == START) || (state_r == WAIT_FFT));

    // Saturating count of samples that arrived while no frame was being loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_cnt_r <= 16'd0;
        end else if (overrun_hit_s && (overrun_cnt_r != 16'hFFFF)) begin
            overrun_cnt_r <= overrun_cnt_r + 16'd1;
        end else begin
            overrun_cnt_r <= overrun_cnt_r;
        end
    end

    assign overrun_cnt = overrun_cnt_r;
`endif

    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign fft_start = fft_start_r;
    assign busy      = (state_r != IDLE);
    assign frame_cnt = frame_cnt_r;

endmodule
